// File: rtl/chain_capture_ctrl.sv
// -----------------------------------------------------------------------------
// chain_capture_ctrl
//
// Non-destructive capture of CHAINS_IN parallel scan chains, CHAIN_DEPTH bits
// each. A start request freezes the functional design and shifts every chain
// for exactly CHAIN_DEPTH cycles. Each chain's scan-out is fed straight back
// into its scan-in, so after the shift every chain holds its original contents.
// The shifted-out bits are collected MSB-first into one capture word per chain.
// The words are then drained to a downstream consumer over valid/ready,
// lowest chain index first.
//
// Ports
//   clk           single clock
//   rst           synchronous, active-high reset
//   start         capture request, only looked at while idle
//   busy          high while shifting or draining
//   chain_freeze  holds the functional design (same as scan_en)
//   scan_en       chain shift enable
//   cin           scan-out bit of each chain
//   scan_in       scan-in bit of each chain (cin recirculated)
//   out_valid     capture word available
//   out_ready     consumer accepts the word
//   out_data      captured word for chain out_idx
//   out_idx       chain index of out_data
//   done          one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module chain_capture_ctrl #(
  parameter int CHAINS_IN   = 1,
  parameter int CHAIN_DEPTH = 8,
  parameter int IDX_W       = 1,
  parameter int CNT_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   chain_freeze,
  output logic                   scan_en,
  input  logic [CHAINS_IN-1:0]   cin,
  output logic [CHAINS_IN-1:0]   scan_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHAIN_DEPTH-1:0] out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   done
);

  // The capture array is sized to the full index space so that out_idx can
  // select from it directly. Slots at or above CHAINS_IN are never drained.
  localparam int NSLOT = 2 ** IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   done_q, done_d;
  logic [CHAIN_DEPTH-1:0] cap_q [NSLOT];
  logic [NSLOT-1:0]       cin_pad;

  logic shift_last;
  logic xfer;
  logic xfer_last;

  // Pure recirculation: a full CHAIN_DEPTH shift leaves every chain restored.
  assign scan_in = cin;
  assign cin_pad = NSLOT'(cin);

  assign shift_last = (cnt_q == CNT_W'(CHAIN_DEPTH - 1));
  assign xfer       = (state_q == ST_DRAIN) && out_ready;
  assign xfer_last  = xfer && (idx_q == IDX_W'(CHAINS_IN - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so that
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end

      ST_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The edge that samples the last bit also leaves SHIFT, so scan_en
        // is high for exactly CHAIN_DEPTH cycles.
        if (shift_last) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (xfer_last) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else if (xfer) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy         = (state_q != ST_IDLE);
    scan_en      = (state_q == ST_SHIFT);
    chain_freeze = (state_q == ST_SHIFT);
    out_valid    = (state_q == ST_DRAIN);
    out_idx      = idx_q;
    out_data     = cap_q[idx_q];
    done         = done_q;
  end

  // ---------------------------------------------------------------------------
  // Capture registers
  // ---------------------------------------------------------------------------
  // Each shift cycle appends the chain's scan-out at the LSB, so the first bit
  // out of the chain ends up in the MSB. Contents hold outside SHIFT.
  // NOTE: the capture array is deliberately cleared by reset so a capture
  // aborted by reset never leaks stale words; this is a small register file,
  // not a RAM, so a reset costs nothing in memory inference.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        cap_q[i] <= '0;
      end
    end else if (state_q == ST_SHIFT) begin
      for (int i = 0; i < NSLOT; i++) begin
        cap_q[i] <= {cap_q[i][CHAIN_DEPTH-2:0], cin_pad[i]};
      end
    end
  end

endmodule

// File: tb/tb_chain_capture_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for chain_capture_ctrl.
//   u_dut : CHAINS_IN=2, CHAIN_DEPTH=8, chains preloaded 0xA5 / 0x3C
//   u_min : CHAINS_IN=1, CHAIN_DEPTH=2, chain preloaded 2'b10
// Chains are modelled as rotators that shift their scan_in in at the LSB and
// present their MSB on cin. Inputs are driven and outputs sampled on the
// falling clock edge. "Cycle c" is the c-th cycle after the edge that
// sampled start=1.
// -----------------------------------------------------------------------------
module tb_chain_capture_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 2-chain, depth-8 instance
  logic       start, busy, chain_freeze, scan_en, out_valid, out_ready, done;
  logic [1:0] cin, scan_in;
  logic [7:0] out_data;
  logic [0:0] out_idx;

  // 1-chain, depth-2 instance
  logic       start_b, busy_b, chain_freeze_b, scan_en_b, out_valid_b;
  logic       out_ready_b, done_b;
  logic [0:0] cin_b, scan_in_b;
  logic [1:0] out_data_b;
  logic [0:0] out_idx_b;

  chain_capture_ctrl #(
    .CHAINS_IN(2), .CHAIN_DEPTH(8), .IDX_W(1), .CNT_W(4)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .chain_freeze(chain_freeze), .scan_en(scan_en), .cin(cin),
    .scan_in(scan_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .done(done)
  );

  chain_capture_ctrl #(
    .CHAINS_IN(1), .CHAIN_DEPTH(2), .IDX_W(1), .CNT_W(2)
  ) u_min (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
    .chain_freeze(chain_freeze_b), .scan_en(scan_en_b), .cin(cin_b),
    .scan_in(scan_in_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_idx(out_idx_b), .done(done_b)
  );

  // Chain models
  logic       ld;
  logic [7:0] ld0, ld1, ch0, ch1;
  logic [1:0] ldb, chb;

  always @(posedge clk) begin
    if (ld) begin
      ch0 <= ld0;
      ch1 <= ld1;
      chb <= ldb;
    end else begin
      if (scan_en) begin
        ch0 <= {ch0[6:0], scan_in[0]};
        ch1 <= {ch1[6:0], scan_in[1]};
      end
      if (scan_en_b) chb <= {chb[0], scan_in_b[0]};
    end
  end

  assign cin   = {ch1[7], ch0[7]};
  assign cin_b = chb[1];

  int n_cmp = 0;
  int n_err = 0;

  // Expected {busy, scan_en, chain_freeze, out_valid, done} for a depth-8,
  // 2-chain capture with out_ready held high, p = cycle index - 1.
  function automatic logic [4:0] ctl_model(input int p);
    if (p > 10) return 5'b0;
    return {p <= 9, p <= 7, p <= 7, (p == 8) || (p == 9), p == 10};
  endfunction

  function automatic logic [8:0] word_model(input int p);
    return (p == 8) ? {1'b0, 8'hA5} : {1'b1, 8'h3C};
  endfunction

  // Called and returns on a falling edge.
  task automatic load_chains(input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] c);
    ld0 = a; ld1 = b; ldb = c; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Full capture with out_ready high, checked cycle by cycle.
  task automatic run_capture(input string tag);
    logic [4:0] got;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      got = {busy, scan_en, chain_freeze, out_valid, done};
      n_cmp++;
      if (got !== ctl_model(c - 1)) begin
        n_err++;
        $display("FAIL %s ctl c=%0d got %b want %b", tag, c, got, ctl_model(c - 1));
      end
      if (c == 9 || c == 10) begin
        n_cmp++;
        if ({out_idx, out_data} !== word_model(c - 1)) begin
          n_err++;
          $display("FAIL %s word c=%0d got idx%0d %h want idx%0d %h", tag, c,
                   out_idx, out_data, word_model(c - 1) >> 8, word_model(c - 1) & 9'hFF);
        end
      end
      n_cmp++;
      if (scan_in !== cin) begin
        n_err++;
        $display("FAIL %s recirc c=%0d got %b want %b", tag, c, scan_in, cin);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({ch1, ch0} !== 16'h3CA5) begin
      n_err++;
      $display("FAIL %s restore got %h %h want 3c a5", tag, ch1, ch0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; start_b = 1'b0;
    out_ready = 1'b0; out_ready_b = 1'b0;
    ld0 = 8'hA5; ld1 = 8'h3C; ldb = 2'b10; ld = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; ld = 1'b0;
    n_cmp++;
    if ({busy, scan_en, chain_freeze, out_valid, done, out_idx, out_data} !== 14'h0) begin
      n_err++;
      $display("FAIL reset dut got %b%b%b%b%b idx%0d %h want all 0", busy, scan_en,
               chain_freeze, out_valid, done, out_idx, out_data);
    end
    n_cmp++;
    if ({busy_b, scan_en_b, chain_freeze_b, out_valid_b, done_b, out_idx_b, out_data_b} !== 8'h0) begin
      n_err++;
      $display("FAIL reset min got %b%b%b%b%b idx%0d %b want all 0", busy_b, scan_en_b,
               chain_freeze_b, out_valid_b, done_b, out_idx_b, out_data_b);
    end
  endtask

  task automatic test_basic();
    load_chains(8'hA5, 8'h3C, 2'b10);
    run_capture("basic");
  endtask

  task automatic test_backpressure();
    logic [4:0] got, want;
    int         n_x;
    logic [0:0] x_idx [4];
    n_x = 0;
    load_chains(8'hA5, 8'h3C, 2'b10);
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      // Stalled through cycle 13 (five cycles after valid rises), then 1/0.
      out_ready = (c >= 14) ? ((c % 2) == 0) : 1'b0;
      got  = {busy, scan_en, chain_freeze, out_valid, done};
      want = {c <= 16, c <= 8, c <= 8, (c >= 9) && (c <= 16), c == 17};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL bp ctl c=%0d got %b want %b", c, got, want);
      end
      if (c >= 9 && c <= 16) begin
        n_cmp++;
        if ({out_idx, out_data} !== ((c <= 14) ? {1'b0, 8'hA5} : {1'b1, 8'h3C})) begin
          n_err++;
          $display("FAIL bp word c=%0d got idx%0d %h", c, out_idx, out_data);
        end
      end
      if (out_valid && out_ready) begin
        if (n_x < 4) x_idx[n_x] = out_idx;
        n_x++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_cmp++;
    if (n_x !== 2) begin
      n_err++;
      $display("FAIL bp xfer_count got %0d want 2", n_x);
    end else begin
      n_cmp++;
      if ({x_idx[0], x_idx[1]} !== 2'b01) begin
        n_err++;
        $display("FAIL bp xfer_order got %b%b want 01", x_idx[0], x_idx[1]);
      end
    end
  endtask

  task automatic test_start_held();
    logic [4:0] got;
    int         p;
    load_chains(8'hA5, 8'h3C, 2'b10);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    // Three back-to-back captures of 11 cycles each; start drops in the last
    // done cycle so no fourth capture begins.
    for (int c = 1; c <= 34; c++) begin
      start = (c < 33);
      p = (c - 1) % 11;
      if (c == 34) p = 11;
      got = {busy, scan_en, chain_freeze, out_valid, done};
      n_cmp++;
      if (got !== ctl_model(p)) begin
        n_err++;
        $display("FAIL held ctl c=%0d got %b want %b", c, got, ctl_model(p));
      end
      if (p == 8 || p == 9) begin
        n_cmp++;
        if ({out_idx, out_data} !== word_model(p)) begin
          n_err++;
          $display("FAIL held word c=%0d got idx%0d %h", c, out_idx, out_data);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    // Reset during the 4th shift cycle.
    load_chains(8'hA5, 8'h3C, 2'b10);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_cmp++;
      if (scan_en !== 1'b1) begin
        n_err++;
        $display("FAIL rst_shift scan_en c=%0d got %b want 1", c, scan_en);
      end
      if (c == 4) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    n_cmp++;
    if ({busy, scan_en, chain_freeze, out_valid, done, out_idx, out_data} !== 14'h0) begin
      n_err++;
      $display("FAIL rst_shift clear got %b%b%b%b%b idx%0d %h want all 0", busy,
               scan_en, chain_freeze, out_valid, done, out_idx, out_data);
    end
    load_chains(8'hA5, 8'h3C, 2'b10);
    run_capture("rst_shift_after");

    // Reset while draining and stalled.
    load_chains(8'hA5, 8'h3C, 2'b10);
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_idx, out_data} !== {1'b1, 1'b0, 8'hA5}) begin
      n_err++;
      $display("FAIL rst_drain pre got v%b idx%0d %h want v1 idx0 a5", out_valid,
               out_idx, out_data);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, scan_en, chain_freeze, out_valid, done, out_idx, out_data} !== 14'h0) begin
      n_err++;
      $display("FAIL rst_drain clear got %b%b%b%b%b idx%0d %h want all 0", busy,
               scan_en, chain_freeze, out_valid, done, out_idx, out_data);
    end
    load_chains(8'hA5, 8'h3C, 2'b10);
    run_capture("rst_drain_after");
  endtask

  task automatic test_min_chain();
    logic [3:0] got, want;
    load_chains(8'hA5, 8'h3C, 2'b10);
    out_ready_b = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      got  = {busy_b, scan_en_b, out_valid_b, done_b};
      want = {c <= 3, c <= 2, c == 3, c == 4};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL min ctl c=%0d got %b want %b", c, got, want);
      end
      if (c == 3) begin
        n_cmp++;
        if ({out_idx_b, out_data_b} !== 3'b010) begin
          n_err++;
          $display("FAIL min word got idx%0d %b want idx0 10", out_idx_b, out_data_b);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (chb !== 2'b10) begin
      n_err++;
      $display("FAIL min restore got %b want 10", chb);
    end
  endtask

  initial begin
    rst = 1'b1;
    ld = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_start_held();
    test_reset_mid();
    test_min_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chain_capture_ctrl.md
Name: chain_capture_ctrl

Overview:
- Sequences a non-destructive capture of CHAINS_IN parallel scan chains, each CHAIN_DEPTH bits long.
- On a start request it freezes the design, asserts the shift enable for exactly CHAIN_DEPTH cycles and recirculates each chain's scan-out back into its scan-in, so chain contents are restored when shifting ends.
- The bits are collected into per-chain capture registers. The block then drains one word per chain to a downstream consumer over a valid/ready handshake.
- Sits between the shadow-capture chains and the chain interpreter / readout logic.

Parameters:
- CHAINS_IN, 1, number of parallel scan chains.
- CHAIN_DEPTH, 8, bits per chain; legal range is 2 or more.
- IDX_W, 1, chain index width; 2^IDX_W >= CHAINS_IN.
- CNT_W, 4, shift counter width; 2^CNT_W > CHAIN_DEPTH.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  capture request; sampled only in IDLE.
- busy  out  1  high in SHIFT and DRAIN.
- chain_freeze  out  1  holds the functional design; equals scan_en.
- scan_en  out  1  chain shift enable.
- cin  in  CHAINS_IN  scan-out bit of each chain.
- scan_in  out  CHAINS_IN  scan-in bit of each chain.
- out_valid  out  1  capture word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  CHAIN_DEPTH  captured word for chain out_idx.
- out_idx  out  IDX_W  chain index of out_data.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - State goes to IDLE.
  - busy, scan_en, chain_freeze, out_valid, done are all 0; out_idx = 0; shift counter = 0.
  - Capture registers are cleared to 0.
  - Reset overrides everything, including mid-SHIFT and mid-DRAIN; a partial capture is discarded. The chains may be left rotated and that is acceptable.
- scan_in[i] = cin[i] combinationally at all times (pure recirculation). A full CHAIN_DEPTH-cycle shift therefore restores each chain.
- IDLE:
  - If start=1 at edge T, go to SHIFT and clear the counter. scan_en is registered high from cycle T+1.
  - start=0 keeps the block in IDLE.
- SHIFT:
  - scan_en = 1 for exactly CHAIN_DEPTH consecutive cycles.
  - Each edge with scan_en=1: cap[i] <= {cap[i][CHAIN_DEPTH-2:0], cin[i]}, and the counter increments.
  - When the counter reaches CHAIN_DEPTH-1 on an edge, go to DRAIN on that edge; scan_en drops on the next cycle.
  - The first bit sampled ends up in cap[i][CHAIN_DEPTH-1] (MSB-first).
  - start is ignored.
- DRAIN:
  - out_valid = 1, out_idx = current index (starts at 0), out_data = cap[out_idx].
  - The transfer occurs on an edge with out_valid & out_ready.
  - Index advances by 1 on each transfer; out_data and out_idx stay stable while out_ready=0.
  - A transfer at index CHAINS_IN-1 sends the block to IDLE, pulses done=1 for one cycle and resets the index to 0.
  - out_ready may stay high continuously, giving one word per cycle.
  - start is ignored.
- Back-to-back: start=1 in the cycle done=1 (state is IDLE) is accepted.
- Latency: start at edge T gives scan_en high during T+1..T+CHAIN_DEPTH, and out_valid first high at T+CHAIN_DEPTH+1. Minimum total is CHAIN_DEPTH+CHAINS_IN+1 cycles to done.
- busy = (state != IDLE). chain_freeze = scan_en. Capture registers hold their value in IDLE.

Test Plan:
1. Basic capture:
   - Setup: CHAINS_IN=2, CHAIN_DEPTH=8. Chain models are 8-bit rotators preloaded with 0xA5 and 0x3C, MSB presented first on cin. start pulsed at T, out_ready=1.
   - Required: scan_en high exactly cycles T+1..T+8. Words (idx0, 0xA5) then (idx1, 0x3C) on consecutive cycles. done one cycle after the second transfer. Chain models read 0xA5 and 0x3C again.
2. Backpressure:
   - Same setup; out_ready=0 for 5 cycles after out_valid rises, then toggles 1/0.
   - Required: out_data=0xA5 and out_idx=0 stable while stalled. Exactly 2 transfers, no duplicates. done only after the idx1 transfer.
3. Start while busy:
   - start held high continuously from T.
   - Required: no re-entry to SHIFT until done. A new capture begins on the done cycle. scan_en asserted exactly 8 cycles per capture.
4. Reset mid-operation:
   - rst=1 at the 4th scan_en cycle; repeat separately with rst=1 while in DRAIN with out_ready=0.
   - Required: next cycle all outputs are 0, state is IDLE, out_idx=0. A subsequent start captures correctly.
5. Single-chain minimum:
   - Setup: CHAINS_IN=1, CHAIN_DEPTH=2, chain preloaded 2'b10, out_ready=1.
   - Required: scan_en high 2 cycles, out_data=2'b10 with out_idx=0, done at T+4.
